// File: rtl/simulador_drone_param_if.sv
// Control and status bundle of the drone simulator core.
// The top level (master) drives buttons and switches; the core (slave) returns flags, position and debug.
interface simulador_drone_param_if #(
    parameter int unsigned COLS  = 16,
    parameter int unsigned ROWS  = 8,
    parameter int unsigned LIVES = 3,
    parameter int unsigned MAPS  = 4
);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned LW = $clog2(LIVES + 1);
    localparam int unsigned MW = (MAPS > 1) ? $clog2(MAPS) : 1;

    logic            iniciar;
    logic            confirma;
    logic [1:0]      controle_vertical;
    logic [1:0]      controle_horizontal;
    logic [1:0]      modo_sel;
    logic [MW-1:0]   mapa_sel;

    logic            venceu;
    logic            perdeu;
    logic            timeout_out;
    logic [CW-1:0]   pos_h;
    logic [RW-1:0]   pos_v;
    logic [LW-1:0]   vidas;
    logic [LW-1:0]   colisoes;
    logic [ROWS-1:0] obstaculo_mask;
    logic [1:0]      db_modo;
    logic [3:0]      db_estado;

    modport master (
        output iniciar, confirma, controle_vertical, controle_horizontal, modo_sel, mapa_sel,
        input  venceu, perdeu, timeout_out, pos_h, pos_v, vidas, colisoes, obstaculo_mask,
               db_modo, db_estado
    );

    modport slave (
        input  iniciar, confirma, controle_vertical, controle_horizontal, modo_sel, mapa_sel,
        output venceu, perdeu, timeout_out, pos_h, pos_v, vidas, colisoes, obstaculo_mask,
               db_modo, db_estado
    );
endinterface

// File: rtl/simulador_drone_param.sv
// Drone simulator core: FSM plus datapath moving a drone across a COLS x ROWS obstacle grid,
// with lives, collision count, manual/auto-scroll modes and an idle timeout.
module simulador_drone_param #(
    parameter int unsigned COLS           = 16,
    parameter int unsigned ROWS           = 8,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned MAPS           = 4,
    parameter int unsigned STEP_CYCLES    = 50000000,
    parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
    input  logic                    clock,
    input  logic                    reset,
    simulador_drone_param_if.slave  bus
);
    localparam int unsigned CW   = $clog2(COLS);
    localparam int unsigned RW   = $clog2(ROWS);
    localparam int unsigned LW   = $clog2(LIVES + 1);
    localparam int unsigned MW   = (MAPS > 1) ? $clog2(MAPS) : 1;
    localparam int unsigned TMAX = (STEP_CYCLES > TIMEOUT_CYCLES) ? STEP_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] H_MAX        = CW'(COLS - 1);
    localparam logic [RW-1:0] V_MAX        = RW'(ROWS - 1);
    localparam logic [RW-1:0] V_START      = RW'(ROWS / 2);
    localparam logic [LW-1:0] LIVES_INIT   = LW'(LIVES);
    localparam logic [TW-1:0] STEP_LAST    = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        StInicial = 4'd0,
        StConfig  = 4'd1,
        StPrepara = 4'd2,
        StEspera  = 4'd3,
        StMove    = 4'd4,
        StCheca   = 4'd5,
        StColidiu = 4'd6,
        StVenceu  = 4'd7,
        StPerdeu  = 4'd8,
        StTimeout = 4'd9
    } estado_t;

    estado_t       estado_q;
    logic          conf_q;
    logic [1:0]    modo_q;
    logic [MW-1:0] mapa_q;
    logic [1:0]    ctrl_v_q;
    logic [1:0]    ctrl_h_q;
    logic [CW-1:0] pos_h_q;
    logic [RW-1:0] pos_v_q;
    logic [LW-1:0] vidas_q;
    logic [LW-1:0] colisoes_q;
    logic [TW-1:0] timer_q;
    logic          venceu_q;
    logic          perdeu_q;
    logic          timeout_q;

    // Odd interior columns carry a single obstacle whose row depends on the map.
    function automatic logic [ROWS-1:0] col_mask(input logic [CW-1:0] c, input logic [MW-1:0] m);
        int unsigned cu;
        int unsigned mu;
        int unsigned r;
        col_mask = '0;
        cu = 32'(c);
        mu = 32'(m);
        if (c != '0 && c != H_MAX && c[0]) begin
            r = (cu * (2 * mu + 3) + mu) % ROWS;
            col_mask = ROWS'(1) << r;
        end
    endfunction

    logic            confirma_pulse;
    logic            modo_auto;
    logic [ROWS-1:0] mask;
    logic            hit;
    logic [1:0]      modo_norm;
    logic [MW-1:0]   mapa_norm;

    always_comb begin
        confirma_pulse = bus.confirma & ~conf_q;
        modo_auto      = (modo_q == 2'd1);
        mask           = col_mask(pos_h_q, mapa_q);
        hit            = mask[pos_v_q];
        modo_norm      = (bus.modo_sel == 2'd1) ? 2'd1 : 2'd0;
        mapa_norm      = (32'(bus.mapa_sel) < MAPS) ? bus.mapa_sel : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= StInicial;
            conf_q     <= 1'b0;
            modo_q     <= '0;
            mapa_q     <= '0;
            ctrl_v_q   <= '0;
            ctrl_h_q   <= '0;
            pos_h_q    <= '0;
            pos_v_q    <= '0;
            vidas_q    <= '0;
            colisoes_q <= '0;
            timer_q    <= '0;
            venceu_q   <= 1'b0;
            perdeu_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            conf_q <= bus.confirma;
            case (estado_q)
                StInicial: begin
                    if (bus.iniciar) estado_q <= StConfig;
                end
                StConfig: begin
                    if (confirma_pulse) begin
                        modo_q   <= modo_norm;
                        mapa_q   <= mapa_norm;
                        estado_q <= StPrepara;
                    end
                end
                StPrepara: begin
                    pos_h_q    <= '0;
                    pos_v_q    <= V_START;
                    vidas_q    <= LIVES_INIT;
                    colisoes_q <= '0;
                    timer_q    <= '0;
                    venceu_q   <= 1'b0;
                    perdeu_q   <= 1'b0;
                    timeout_q  <= 1'b0;
                    estado_q   <= StEspera;
                end
                StEspera: begin
                    timer_q <= timer_q + 1'b1;
                    if (modo_auto) begin
                        // Auto-scroll always advances; only the vertical control is honoured.
                        if (timer_q == STEP_LAST) begin
                            ctrl_v_q <= bus.controle_vertical;
                            ctrl_h_q <= 2'b01;
                            estado_q <= StMove;
                        end
                    end else if (confirma_pulse) begin
                        ctrl_v_q <= bus.controle_vertical;
                        ctrl_h_q <= bus.controle_horizontal;
                        estado_q <= StMove;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timeout_q <= 1'b1;
                        estado_q  <= StTimeout;
                    end
                end
                StMove: begin
                    if (ctrl_v_q == 2'b01 && pos_v_q != V_MAX) pos_v_q <= pos_v_q + 1'b1;
                    else if (ctrl_v_q == 2'b10 && pos_v_q != '0) pos_v_q <= pos_v_q - 1'b1;
                    if (ctrl_h_q == 2'b01 && pos_h_q != H_MAX) pos_h_q <= pos_h_q + 1'b1;
                    else if (ctrl_h_q == 2'b10 && pos_h_q != '0) pos_h_q <= pos_h_q - 1'b1;
                    timer_q  <= '0;
                    estado_q <= StCheca;
                end
                StCheca: begin
                    if (hit) begin
                        estado_q <= StColidiu;
                    end else if (pos_h_q == H_MAX) begin
                        venceu_q <= 1'b1;
                        estado_q <= StVenceu;
                    end else begin
                        estado_q <= StEspera;
                    end
                end
                StColidiu: begin
                    vidas_q <= vidas_q - 1'b1;
                    if (colisoes_q != LIVES_INIT) colisoes_q <= colisoes_q + 1'b1;
                    if (vidas_q == LW'(1)) begin
                        perdeu_q <= 1'b1;
                        estado_q <= StPerdeu;
                    end else begin
                        estado_q <= StEspera;
                    end
                end
                StVenceu, StPerdeu, StTimeout: begin
                    if (bus.iniciar) begin
                        venceu_q  <= 1'b0;
                        perdeu_q  <= 1'b0;
                        timeout_q <= 1'b0;
                        estado_q  <= StConfig;
                    end
                end
                default: estado_q <= StInicial;
            endcase
        end
    end

    assign bus.venceu         = venceu_q;
    assign bus.perdeu         = perdeu_q;
    assign bus.timeout_out    = timeout_q;
    assign bus.pos_h          = pos_h_q;
    assign bus.pos_v          = pos_v_q;
    assign bus.vidas          = vidas_q;
    assign bus.colisoes       = colisoes_q;
    assign bus.obstaculo_mask = mask;
    assign bus.db_modo        = modo_q;
    assign bus.db_estado      = estado_q;
endmodule

// File: tb/tb_simulador_drone_param.sv
// Directed bench for simulador_drone_param: short step/timeout constants, default grid, maps 0 and 1.
module tb_simulador_drone_param;
    localparam int unsigned COLS  = 16;
    localparam int unsigned ROWS  = 8;
    localparam int unsigned LIVES = 3;
    localparam int unsigned MAPS  = 4;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    simulador_drone_param_if #(.COLS(COLS), .ROWS(ROWS), .LIVES(LIVES), .MAPS(MAPS)) bus ();

    simulador_drone_param #(
        .COLS(COLS), .ROWS(ROWS), .LIVES(LIVES), .MAPS(MAPS),
        .STEP_CYCLES(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_game(input logic [1:0] modo, input logic [1:0] mapa);
        bus.iniciar = 1'b1;
        tick(1);
        bus.iniciar  = 1'b0;
        bus.modo_sel = modo;
        bus.mapa_sel = mapa;
        bus.confirma = 1'b1;
        tick(1);
        bus.confirma = 1'b0;
        tick(1);
    endtask

    // One manual move: pulse edge, MOVE, CHECA, then one more clock for a collision to resolve.
    task automatic move(input logic [1:0] h, input logic [1:0] v);
        bus.controle_horizontal = h;
        bus.controle_vertical   = v;
        bus.confirma            = 1'b1;
        tick(1);
        bus.confirma = 1'b0;
        tick(3);
    endtask

    logic [2:0] exp_v [4] = '{3'd5, 3'd6, 3'd7, 3'd7};

    initial begin
        reset                   = 1'b1;
        bus.iniciar             = 1'b0;
        bus.confirma            = 1'b0;
        bus.controle_vertical   = 2'b00;
        bus.controle_horizontal = 2'b00;
        bus.modo_sel            = 2'd0;
        bus.mapa_sel            = 2'd0;
        tick(2);
        reset = 1'b0;
        check("rst_estado", 32'(bus.db_estado), 0);
        check("rst_vidas", 32'(bus.vidas), 0);

        // T1: reset in the middle of a game
        start_game(2'd0, 2'd0);
        check("prep_estado", 32'(bus.db_estado), 3);
        check("prep_pos_v", 32'(bus.pos_v), 4);
        check("prep_vidas", 32'(bus.vidas), 3);
        for (int i = 0; i < 5; i++) move(2'b01, 2'b00);
        check("t1_pos_h", 32'(bus.pos_h), 5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t1_estado", 32'(bus.db_estado), 0);
        check("t1_pos_h0", 32'(bus.pos_h), 0);
        check("t1_pos_v0", 32'(bus.pos_v), 0);
        check("t1_vidas0", 32'(bus.vidas), 0);
        check("t1_colis0", 32'(bus.colisoes), 0);
        check("t1_flags0", {29'd0, bus.venceu, bus.perdeu, bus.timeout_out}, 0);
        check("t1_mask0", 32'(bus.obstaculo_mask), 0);
        check("t1_modo0", 32'(bus.db_modo), 0);

        // T2: forward+down onto the obstacle at (1,3), stepping through the latency
        start_game(2'd0, 2'd0);
        bus.controle_horizontal = 2'b01;
        bus.controle_vertical   = 2'b10;
        bus.confirma            = 1'b1;
        tick(1);
        bus.confirma = 1'b0;
        check("t2_st_move", 32'(bus.db_estado), 4);
        tick(1);
        check("t2_st_checa", 32'(bus.db_estado), 5);
        check("t2_pos_h", 32'(bus.pos_h), 1);
        check("t2_pos_v", 32'(bus.pos_v), 3);
        check("t2_mask", 32'(bus.obstaculo_mask), 32'h08);
        tick(1);
        check("t2_st_colid", 32'(bus.db_estado), 6);
        tick(1);
        check("t2_st_espera", 32'(bus.db_estado), 3);
        check("t2_vidas", 32'(bus.vidas), 2);
        check("t2_colis", 32'(bus.colisoes), 1);

        // T5: staying on the obstacle costs the remaining lives
        move(2'b00, 2'b00);
        check("t5_vidas1", 32'(bus.vidas), 1);
        check("t5_colis2", 32'(bus.colisoes), 2);
        move(2'b00, 2'b00);
        check("t5_vidas0", 32'(bus.vidas), 0);
        check("t5_perdeu", 32'(bus.perdeu), 1);
        check("t5_colis3", 32'(bus.colisoes), 3);
        check("t5_estado", 32'(bus.db_estado), 8);
        move(2'b01, 2'b01);
        check("t5_frozen_h", 32'(bus.pos_h), 1);
        check("t5_frozen_st", 32'(bus.db_estado), 8);

        // T3: saturation at column 0, no-op controls, then a clean run to the goal
        start_game(2'd0, 2'd0);
        check("t3_perdeu_clr", 32'(bus.perdeu), 0);
        move(2'b10, 2'b00);
        check("t3_back_sat", 32'(bus.pos_h), 0);
        move(2'b11, 2'b11);
        check("t3_none_h", 32'(bus.pos_h), 0);
        check("t3_none_v", 32'(bus.pos_v), 4);
        for (int i = 0; i < 15; i++) move(2'b01, 2'b00);
        check("t3_venceu", 32'(bus.venceu), 1);
        check("t3_pos_h", 32'(bus.pos_h), 15);
        check("t3_pos_v", 32'(bus.pos_v), 4);
        check("t3_vidas", 32'(bus.vidas), 3);
        check("t3_colis", 32'(bus.colisoes), 0);
        check("t3_estado", 32'(bus.db_estado), 7);
        move(2'b01, 2'b00);
        check("t3_ignored", 32'(bus.db_estado), 7);

        // T4: idle timeout in manual mode
        start_game(2'd0, 2'd0);
        check("t4_venceu_clr", 32'(bus.venceu), 0);
        tick(7);
        check("t4_still_wait", 32'(bus.db_estado), 3);
        check("t4_no_to_yet", 32'(bus.timeout_out), 0);
        tick(1);
        check("t4_timeout", 32'(bus.timeout_out), 1);
        check("t4_estado9", 32'(bus.db_estado), 9);
        bus.iniciar = 1'b1;
        tick(1);
        bus.iniciar = 1'b0;
        check("t4_config", 32'(bus.db_estado), 1);
        check("t4_to_clr", 32'(bus.timeout_out), 0);

        // T6: auto-scroll with up held; back request must be ignored
        bus.modo_sel            = 2'd1;
        bus.mapa_sel            = 2'd0;
        bus.controle_vertical   = 2'b01;
        bus.controle_horizontal = 2'b10;
        bus.confirma            = 1'b1;
        tick(1);
        bus.confirma = 1'b0;
        tick(1);
        check("t6_modo", 32'(bus.db_modo), 1);
        for (int k = 0; k < 4; k++) begin
            tick(6);
            check("t6_pos_h", 32'(bus.pos_h), 32'(k + 1));
            check("t6_pos_v", 32'(bus.pos_v), 32'(exp_v[k]));
        end
        tick(6);
        check("t6_colid", 32'(bus.db_estado), 6);
        check("t6_hit_h", 32'(bus.pos_h), 5);
        tick(1);
        check("t6_vidas", 32'(bus.vidas), 2);
        check("t6_colis", 32'(bus.colisoes), 1);

        // Map 1 puts the column-1 obstacle on row 6
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        bus.controle_vertical = 2'b00;
        start_game(2'd0, 2'd1);
        move(2'b01, 2'b00);
        check("m1_mask", 32'(bus.obstaculo_mask), 32'h40);
        check("m1_vidas", 32'(bus.vidas), 3);
        move(2'b01, 2'b00);
        check("m1_mask_even", 32'(bus.obstaculo_mask), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
